// File: rtl/io_timer_pkg.sv
// Shared register map, bit positions and IRQ state encoding for io_timer_intr.
package io_timer_pkg;
   // Register offsets are word indices taken from io_address[4:2].
   localparam logic [2:0] OFS_CTRL   = 3'd0;
   localparam logic [2:0] OFS_LOAD   = 3'd1;
   localparam logic [2:0] OFS_COUNT  = 3'd2;
   localparam logic [2:0] OFS_STATUS = 3'd3;
   localparam logic [2:0] OFS_PRESC  = 3'd4;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_AUTO = 1;
   localparam int CTRL_IE   = 2;
   localparam int ST_EXP    = 0;
   localparam int ST_OVR    = 1;

   localparam int PRESC_W = 16;

   typedef enum logic [1:0] {
      I_IDLE = 2'd0,
      I_REQ  = 2'd1,
      I_ACK  = 2'd2
   } irq_state_e;
endpackage

// File: rtl/io_timer_prescaler.sv
// Tick generator: one tick every presc+1 clocks, realigned whenever restart is pulsed.
module io_timer_prescaler
   import io_timer_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               restart,
   input  logic [PRESC_W-1:0] presc,
   output logic               tick
);
   logic [PRESC_W-1:0] cnt_d;
   logic [PRESC_W-1:0] cnt_q;

   // >= keeps the divider from running away if presc shrinks below the current count
   assign tick = (cnt_q >= presc);

   // next divider count
   always_comb begin
      cnt_d = cnt_q;
      if (restart) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + PRESC_W'(1);
      end
   end

   // divider state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/io_timer_intr.sv
// Memory-mapped down-counter timer with interrupt request/acknowledge handshake.
// Optional feature macro: TIMER_PRESCALE_EN (adds the PRESC register and tick prescaler).
module io_timer_intr
   import io_timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0F00,
   parameter int          CNT_W     = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        io_cs,
   input  logic        io_rd,
   input  logic        io_wr,
   input  logic [31:0] io_address,
   input  logic [31:0] io_d_in,
   output logic [31:0] io_out,
   input  logic        inta,
   output logic        intr
);
   logic [2:0]       ctrl_d, ctrl_q;
   logic [CNT_W-1:0] load_d, load_q;
   logic [CNT_W-1:0] count_d, count_q;
   logic             exp_d, exp_q;
   logic             ovr_d, ovr_q;
   irq_state_e       irq_q;
   logic             pend_q;
   logic             intr_q;

   logic        hit_s, we_s, rd_s;
   logic [2:0]  ofs_s;
   logic        wr_ctrl_s, wr_load_s, wr_status_s;
   logic        en_rise_s, tick_s, expire_s, event_s;
   logic        ack_done_s, pend_avail_s, ovr_set_s;
   logic [31:0] rdata_s;
   logic        unused_s;

   assign hit_s       = (io_address[31:5] == BASE_ADDR[31:5]);
   assign ofs_s       = io_address[4:2];
   assign we_s        = io_cs & io_wr & hit_s;
   assign rd_s        = io_cs & io_rd & hit_s;
   assign wr_ctrl_s   = we_s & (ofs_s == OFS_CTRL);
   assign wr_load_s   = we_s & (ofs_s == OFS_LOAD);
   assign wr_status_s = we_s & (ofs_s == OFS_STATUS);
   assign unused_s    = ^io_address[1:0];

   assign en_rise_s    = wr_ctrl_s & io_d_in[CTRL_EN] & ~ctrl_q[CTRL_EN];
   assign expire_s     = ctrl_q[CTRL_EN] & tick_s & (count_q == '0);
   assign event_s      = expire_s & ctrl_q[CTRL_IE];
   assign ack_done_s   = (irq_q == I_ACK) & ~inta;
   // A pending request being consumed this cycle frees the slot for a new event.
   assign pend_avail_s = pend_q & ~ack_done_s;
   assign ovr_set_s    = event_s & (irq_q != I_IDLE) & pend_avail_s;

`ifdef TIMER_PRESCALE_EN
   logic [PRESC_W-1:0] presc_q;
   logic               wr_presc_s;

   assign wr_presc_s = we_s & (ofs_s == OFS_PRESC);

   // prescaler divisor register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_q <= '0;
      end else if (wr_presc_s) begin
         presc_q <= io_d_in[PRESC_W-1:0];
      end else begin
         presc_q <= presc_q;
      end
   end

   io_timer_prescaler u_presc (
      .clk     (clk),
      .rst_n   (reset),
      .restart (en_rise_s | wr_presc_s),
      .presc   (presc_q),
      .tick    (tick_s)
   );
`else
   assign tick_s = 1'b1;
`endif

   // next-state for the programmable registers and the counter
   always_comb begin
      if (en_rise_s) begin
         count_d = load_q;
      end else if (expire_s && ctrl_q[CTRL_AUTO]) begin
         count_d = load_q;
      end else if (ctrl_q[CTRL_EN] && tick_s && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end else begin
         count_d = count_q;
      end

      // A CTRL write lands after any same-cycle expiry has been processed.
      ctrl_d = ctrl_q;
      if (wr_ctrl_s) begin
         ctrl_d = io_d_in[2:0];
      end else if (expire_s && !ctrl_q[CTRL_AUTO]) begin
         ctrl_d[CTRL_EN] = 1'b0;
      end else begin
         ctrl_d = ctrl_q;
      end

      if (wr_load_s) begin
         load_d = io_d_in[CNT_W-1:0];
      end else begin
         load_d = load_q;
      end

      exp_d = (exp_q & ~(wr_status_s & io_d_in[ST_EXP])) | expire_s;
      ovr_d = (ovr_q & ~(wr_status_s & io_d_in[ST_OVR])) | ovr_set_s;
   end

   // register file and counter state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_q  <= 3'd0;
         load_q  <= '0;
         count_q <= '0;
         exp_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         ctrl_q  <= ctrl_d;
         load_q  <= load_d;
         count_q <= count_d;
         exp_q   <= exp_d;
         ovr_q   <= ovr_d;
      end
   end

   // interrupt handshake FSM with a single-deep pending slot
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_q  <= I_IDLE;
         intr_q <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         case (irq_q)
            I_IDLE: begin
               if (event_s) begin
                  irq_q  <= I_REQ;
                  intr_q <= 1'b1;
               end else begin
                  irq_q  <= I_IDLE;
                  intr_q <= 1'b0;
               end
            end
            I_REQ: begin
               if (inta) begin
                  irq_q  <= I_ACK;
                  intr_q <= 1'b0;
               end else begin
                  irq_q  <= I_REQ;
                  intr_q <= 1'b1;
               end
            end
            I_ACK: begin
               if (!inta && (pend_q || event_s)) begin
                  irq_q  <= I_REQ;
                  intr_q <= 1'b1;
               end else if (!inta) begin
                  irq_q  <= I_IDLE;
                  intr_q <= 1'b0;
               end else begin
                  irq_q  <= I_ACK;
                  intr_q <= 1'b0;
               end
            end
            default: begin
               irq_q  <= I_IDLE;
               intr_q <= 1'b0;
            end
         endcase

         // Leaving I_ACK consumes one request; a second source keeps the slot full.
         if (ack_done_s) begin
            pend_q <= pend_q & event_s;
         end else if (event_s && (irq_q != I_IDLE)) begin
            pend_q <= 1'b1;
         end else begin
            pend_q <= pend_q;
         end
      end
   end

   // combinational read mux
   always_comb begin
      rdata_s = 32'd0;
      case (ofs_s)
         OFS_CTRL:   rdata_s = {29'd0, ctrl_q};
         OFS_LOAD:   rdata_s = 32'(load_q);
         OFS_COUNT:  rdata_s = 32'(count_q);
         OFS_STATUS: rdata_s = {30'd0, ovr_q, exp_q};
`ifdef TIMER_PRESCALE_EN
         OFS_PRESC:  rdata_s = {16'd0, presc_q};
`endif
         default:    rdata_s = 32'd0;
      endcase
   end

   assign io_out = rd_s ? rdata_s : 32'hzzzz_zzzz;
   assign intr   = intr_q;
endmodule

// File: tb/tb_io_timer_intr.sv
// Scoreboard bench for io_timer_intr: directed stimulus queues expectations, a monitor checks them.
module tb_io_timer_intr;
   import io_timer_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_0F00;

   typedef struct {
      string       name;
      bit          is_read;
      logic [31:0] data;
      logic        intr;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        io_cs = 1'b0;
   logic        io_rd = 1'b0;
   logic        io_wr = 1'b0;
   logic [31:0] io_address = 32'd0;
   logic [31:0] io_d_in = 32'd0;
   wire  [31:0] io_out;
   logic        inta = 1'b0;
   logic        intr;

   logic chk_s = 1'b0;
   logic drain_s = 1'b0;
   exp_t sb_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad = 0;

   io_timer_intr dut (
      .clk        (clk),
      .reset      (reset),
      .io_cs      (io_cs),
      .io_rd      (io_rd),
      .io_wr      (io_wr),
      .io_address (io_address),
      .io_d_in    (io_d_in),
      .io_out     (io_out),
      .inta       (inta),
      .intr       (intr)
   );

   always #5 clk = ~clk;

   // monitor: pops one expectation per sampled cycle on the falling edge
   always @(negedge clk) begin
      if (chk_s) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: sample with no expectation queued");
         end else begin
            mon_e = sb_q.pop_front();
            if (mon_e.is_read) begin
               total++;
               if (io_out !== mon_e.data) begin
                  bad++;
                  $display("FAIL %s io_out: got %h want %h", mon_e.name, io_out, mon_e.data);
               end
            end
            total++;
            if (intr !== mon_e.intr) begin
               bad++;
               $display("FAIL %s intr: got %b want %b", mon_e.name, intr, mon_e.intr);
            end
         end
      end
      if (drain_s) begin
         total++;
         if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d left want 0", sb_q.size());
         end
      end
   end

   task automatic wr(input logic [2:0] ofs, input logic [31:0] d);
      io_cs = 1'b1;
      io_wr = 1'b1;
      io_address = BASE | {27'd0, ofs, 2'b00};
      io_d_in = d;
      @(posedge clk);
      #1;
      io_cs = 1'b0;
      io_wr = 1'b0;
   endtask

   task automatic smp(input bit rd, input logic [2:0] ofs, input logic [31:0] d,
                      input logic ei, input string nm);
      exp_t e;
      e.name = nm;
      e.is_read = rd;
      e.data = d;
      e.intr = ei;
      sb_q.push_back(e);
      io_cs = rd;
      io_rd = rd;
      io_address = BASE | {27'd0, ofs, 2'b00};
      chk_s = 1'b1;
      @(posedge clk);
      #1;
      io_cs = 1'b0;
      io_rd = 1'b0;
      chk_s = 1'b0;
   endtask

   initial begin
      @(posedge clk);
      #1;
      smp(1'b1, OFS_CTRL,  32'd0, 1'b0, "rst_ctrl");
      smp(1'b1, OFS_COUNT, 32'd0, 1'b0, "rst_count");
      reset = 1'b1;

      // one-shot countdown with interrupt
      wr(OFS_LOAD, 32'd3);
      wr(OFS_CTRL, 32'd5);
      smp(1'b1, OFS_COUNT,  32'd3, 1'b0, "t1_cnt3");
      smp(1'b1, OFS_COUNT,  32'd2, 1'b0, "t1_cnt2");
      smp(1'b1, OFS_COUNT,  32'd1, 1'b0, "t1_cnt1");
      smp(1'b1, OFS_COUNT,  32'd0, 1'b0, "t1_cnt0");
      smp(1'b1, OFS_STATUS, 32'd1, 1'b1, "t1_exp");
      smp(1'b1, OFS_CTRL,   32'd4, 1'b1, "t1_en_off");
      smp(1'b1, OFS_LOAD,   32'd3, 1'b1, "t1_load");

      // acknowledge handshake
      inta = 1'b1;
      smp(1'b0, OFS_CTRL, 32'd0, 1'b1, "t2_intr_hold");
      inta = 1'b0;
      smp(1'b0, OFS_CTRL, 32'd0, 1'b0, "t2_intr_fall");
      smp(1'b0, OFS_CTRL, 32'd0, 1'b0, "t2_idle");
      smp(1'b0, OFS_CTRL, 32'd0, 1'b0, "t2_idle2");
      wr(OFS_STATUS, 32'd1);
      smp(1'b1, OFS_STATUS, 32'd0, 1'b0, "t2_exp_clr");

      // expiry and W1C in the same cycle
      wr(OFS_LOAD, 32'd1);
      wr(OFS_CTRL, 32'd1);
      smp(1'b1, OFS_COUNT, 32'd1, 1'b0, "t4_cnt1");
      wr(OFS_STATUS, 32'd1);
      smp(1'b1, OFS_STATUS, 32'd1, 1'b0, "t4_set_wins");
      smp(1'b1, OFS_CTRL,   32'd0, 1'b0, "t4_stop");
      wr(OFS_STATUS, 32'd1);
      smp(1'b1, OFS_STATUS, 32'd0, 1'b0, "t4_w1c");
      wr(OFS_COUNT, 32'd9);
      smp(1'b1, OFS_COUNT, 32'd0, 1'b0, "count_ro");
      smp(1'b1, 3'd7,      32'd0, 1'b0, "unmapped");

      // LOAD=0 auto-reload: pending and overrun
      wr(OFS_LOAD, 32'd0);
      wr(OFS_CTRL, 32'd7);
      smp(1'b1, OFS_STATUS, 32'd0, 1'b0, "t3_pre");
      smp(1'b1, OFS_STATUS, 32'd1, 1'b1, "t3_exp1");
      smp(1'b1, OFS_STATUS, 32'd1, 1'b1, "t3_pend");
      smp(1'b1, OFS_STATUS, 32'd3, 1'b1, "t3_ovr");
      wr(OFS_CTRL, 32'd0);
      smp(1'b1, OFS_CTRL, 32'd0, 1'b1, "t3_stopped");
      inta = 1'b1;
      smp(1'b0, OFS_CTRL, 32'd0, 1'b1, "t3_ack1");
      inta = 1'b0;
      smp(1'b0, OFS_CTRL, 32'd0, 1'b0, "t3_gap");
      smp(1'b0, OFS_CTRL, 32'd0, 1'b1, "t3_rereq");
      inta = 1'b1;
      smp(1'b0, OFS_CTRL, 32'd0, 1'b1, "t3_ack2");
      inta = 1'b0;
      smp(1'b0, OFS_CTRL, 32'd0, 1'b0, "t3_drop");
      smp(1'b0, OFS_CTRL, 32'd0, 1'b0, "t3_idle");
      smp(1'b0, OFS_CTRL, 32'd0, 1'b0, "t3_idle2");
      wr(OFS_STATUS, 32'd3);
      smp(1'b1, OFS_STATUS, 32'd0, 1'b0, "t3_clr");

      // asynchronous reset in the middle of a count with intr high
      wr(OFS_LOAD, 32'd0);
      wr(OFS_CTRL, 32'd5);
      wr(OFS_LOAD, 32'd7);
      wr(OFS_CTRL, 32'd5);
      smp(1'b1, OFS_COUNT, 32'd7, 1'b1, "t5_cnt7");
      smp(1'b1, OFS_COUNT, 32'd6, 1'b1, "t5_cnt6");
      reset = 1'b0;
      #1;
      smp(1'b1, OFS_COUNT,  32'd0, 1'b0, "t5_rst_count");
      smp(1'b1, OFS_CTRL,   32'd0, 1'b0, "t5_rst_ctrl");
      smp(1'b1, OFS_STATUS, 32'd0, 1'b0, "t5_rst_status");
      smp(1'b1, OFS_LOAD,   32'd0, 1'b0, "t5_rst_load");
      reset = 1'b1;

`ifdef TIMER_PRESCALE_EN
      // prescaled tick: PRESC=2, LOAD=1 expires six clocks after enable
      wr(OFS_PRESC, 32'd2);
      wr(OFS_LOAD, 32'd1);
      wr(OFS_CTRL, 32'd1);
      for (int i = 0; i < 6; i++) begin
         smp(1'b1, OFS_STATUS, 32'd0, 1'b0, "t6_wait");
      end
      smp(1'b1, OFS_STATUS, 32'd1, 1'b0, "t6_exp");
      smp(1'b1, OFS_PRESC,  32'd2, 1'b0, "t6_presc");
`endif

      drain_s = 1'b1;
      @(posedge clk);
      #1;
      drain_s = 1'b0;
      @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
